// File: rtl/peripheral_operand_loader_pkg.sv
// Shared types and helpers for the operand loader and its byte bank.
package peripheral_operand_loader_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FILL = 2'd1,
      S_FULL = 2'd2
   } ldr_state_t;

   // Index width for a bank of n bytes; at least one bit so a single-byte bank still has a port.
   function automatic int addr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/operand_byte_bank.sv
// TOTAL x 8 byte register array: one stream write port, optional addressed port
// (OPLOADER_ADDR_WR_EN), flat little-endian byte output.
module operand_byte_bank
   import peripheral_operand_loader_pkg::*;
#(
   parameter int TOTAL  = 8,
   parameter int PTR_W  = 4,
   parameter int ADDR_W = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     stream_we,
   input  logic [PTR_W-1:0]         stream_idx,
   input  logic [BYTE_W-1:0]        stream_data,
`ifdef OPLOADER_ADDR_WR_EN
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [BYTE_W-1:0]        wr_data,
`endif
   output logic [TOTAL*BYTE_W-1:0]  ops
);

   logic [BYTE_W-1:0] bytes [TOTAL];
   logic [TOTAL-1:0]  addr_hit;

`ifdef OPLOADER_ADDR_WR_EN
   // Out-of-range addresses match no lane and are dropped.
   always_comb begin
      addr_hit = '0;
      for (int i = 0; i < TOTAL; i++) begin
         addr_hit[i] = wr_en && (wr_addr == ADDR_W'(i));
      end
   end
`else
   assign addr_hit = '0;
`endif

   // Addressed write beats a stream write to the same byte.
   always_ff @(posedge clk) begin
      for (int i = 0; i < TOTAL; i++) begin
         if (reset) begin
            bytes[i] <= '0;
         end else if (addr_hit[i]) begin
`ifdef OPLOADER_ADDR_WR_EN
            bytes[i] <= wr_data;
`endif
         end else if (stream_we && (stream_idx == PTR_W'(i))) begin
            bytes[i] <= stream_data;
         end
      end
   end

   for (genvar g = 0; g < TOTAL; g++) begin : g_flat
      assign ops[g*BYTE_W +: BYTE_W] = bytes[g];
   end

endmodule

// File: rtl/peripheral_operand_loader.sv
// Assembles NUM_OPS operands from a byte stream and holds them until acknowledged.
// Optional addressed byte write port: define OPLOADER_ADDR_WR_EN.
module peripheral_operand_loader
   import peripheral_operand_loader_pkg::*;
#(
   parameter int NUM_OPS  = 2,
   parameter int OP_WIDTH = 32,
   localparam int BPO     = OP_WIDTH / BYTE_W,
   localparam int TOTAL   = NUM_OPS * BPO,
   localparam int PTR_W   = $clog2(TOTAL + 1),
   localparam int ADDR_W  = addr_width(TOTAL)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [BYTE_W-1:0]           in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic                        clear,
   input  logic                        ops_ack,
   output logic                        ops_valid,
   output logic [NUM_OPS*OP_WIDTH-1:0] ops,
   output logic [PTR_W-1:0]            byte_count,
   output logic                        err_overrun,
`ifdef OPLOADER_ADDR_WR_EN
   input  logic                        wr_en,
   input  logic [ADDR_W-1:0]           wr_addr,
   input  logic [BYTE_W-1:0]           wr_data,
`endif
   output ldr_state_t                  fsm_state
);

   // Handshake: a byte transfers on a rising edge where in_valid && in_ready and
   // clear is low; in_ready depends on state only, so the source may not wait on
   // it combinationally. ops are held stable while ops_valid until ops_ack.
   ldr_state_t        state;
   ldr_state_t        next_state;
   logic              accept;
   logic              last_byte;
   logic [PTR_W-1:0]  count;
   logic              overrun;

   assign last_byte = (count == PTR_W'(TOTAL - 1));
   assign fsm_state = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else if (clear) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: if (accept) next_state = last_byte ? S_FULL : S_FILL;
         S_FILL: if (accept && last_byte) next_state = S_FULL;
         S_FULL: if (ops_ack) next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state != S_FULL);
      ops_valid = (state == S_FULL);
      accept    = in_valid && in_ready && !clear;
   end

   // Count stops at TOTAL because no byte is accepted in S_FULL.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if ((state == S_FULL) && ops_ack) begin
         count <= '0;
      end else if (accept && (count != PTR_W'(TOTAL))) begin
         count <= count + PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         overrun <= 1'b0;
      end else if ((state == S_FULL) && in_valid) begin
         overrun <= 1'b1;
      end
   end

   assign byte_count  = count;
   assign err_overrun = overrun;

   operand_byte_bank #(
      .TOTAL  (TOTAL),
      .PTR_W  (PTR_W),
      .ADDR_W (ADDR_W)
   ) u_bank (
      .clk         (clk),
      .reset       (reset),
      .stream_we   (accept),
      .stream_idx  (count),
      .stream_data (in_data),
`ifdef OPLOADER_ADDR_WR_EN
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
`endif
      .ops         (ops)
   );

endmodule

// File: tb/tb_peripheral_operand_loader.sv
// Directed table-driven bench for peripheral_operand_loader; OPLOADER_ADDR_WR_EN
// selects the 3x16 addressed-write configuration.
module tb_peripheral_operand_loader;
   import peripheral_operand_loader_pkg::*;

`ifdef OPLOADER_ADDR_WR_EN
   localparam int NUM_OPS  = 3;
   localparam int OP_WIDTH = 16;
`else
   localparam int NUM_OPS  = 2;
   localparam int OP_WIDTH = 32;
`endif
   localparam int TOTAL  = NUM_OPS * OP_WIDTH / 8;
   localparam int PTR_W  = $clog2(TOTAL + 1);
   localparam int ADDR_W = addr_width(TOTAL);
   localparam int OPS_W  = NUM_OPS * OP_WIDTH;

   typedef struct {
      logic             rst;
      logic             vld;
      logic [7:0]       data;
      logic             clr;
      logic             ack;
      logic             wen;
      logic [ADDR_W-1:0] waddr;
      logic [7:0]       wdata;
      logic             erdy;
      logic             evld;
      int               ecnt;
      logic             eerr;
      logic             chk;
      logic [OPS_W-1:0] eops;
   } vec_t;

   vec_t vec_q[$];
   int   checks = 0;
   int   errors = 0;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic [7:0]         in_data = '0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic               clear = 1'b0;
   logic               ops_ack = 1'b0;
   logic               ops_valid;
   logic [OPS_W-1:0]   ops;
   logic [PTR_W-1:0]   byte_count;
   logic               err_overrun;
   logic               wr_en = 1'b0;
   logic [ADDR_W-1:0]  wr_addr = '0;
   logic [7:0]         wr_data = '0;
   ldr_state_t         fsm_state;

   always #5 clk = ~clk;

   peripheral_operand_loader #(
      .NUM_OPS  (NUM_OPS),
      .OP_WIDTH (OP_WIDTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .clear       (clear),
      .ops_ack     (ops_ack),
      .ops_valid   (ops_valid),
      .ops         (ops),
      .byte_count  (byte_count),
      .err_overrun (err_overrun),
`ifdef OPLOADER_ADDR_WR_EN
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
`endif
      .fsm_state   (fsm_state)
   );

   task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
      end
   endtask

   task automatic add(input logic rst, input logic vld, input logic [7:0] d, input logic clr,
                      input logic ack, input logic erdy, input logic evld, input int ecnt,
                      input logic eerr, input logic chk, input logic [OPS_W-1:0] eops);
      vec_t v;
      v.rst = rst; v.vld = vld; v.data = d; v.clr = clr; v.ack = ack;
      v.wen = 1'b0; v.waddr = '0; v.wdata = '0;
      v.erdy = erdy; v.evld = evld; v.ecnt = ecnt; v.eerr = eerr;
      v.chk = chk; v.eops = eops;
      vec_q.push_back(v);
   endtask

   // n back-to-back bytes base, base+1, ... starting from count 'start'.
   task automatic stream(input logic [7:0] base, input int n, input int start);
      for (int i = 0; i < n; i++) begin
         add(0, 1, 8'(base + i), 0, 0, (start + i + 1) < TOTAL, (start + i + 1) == TOTAL,
             start + i + 1, 0, 0, '0);
      end
   endtask

   task automatic set_wr(input int idx, input logic [ADDR_W-1:0] a, input logic [7:0] d);
      vec_q[idx].wen = 1'b1;
      vec_q[idx].waddr = a;
      vec_q[idx].wdata = d;
   endtask

   task automatic compare_outputs(input int idx, input logic erdy, input logic evld, input int ecnt,
                                  input logic eerr);
      ldr_state_t est;
      est = evld ? S_FULL : ((ecnt == 0) ? S_IDLE : S_FILL);
      check("in_ready", idx, 64'(in_ready), 64'(erdy));
      check("ops_valid", idx, 64'(ops_valid), 64'(evld));
      check("byte_count", idx, 64'(byte_count), 64'(ecnt));
      check("err_overrun", idx, 64'(err_overrun), 64'(eerr));
      check("state", idx, 64'(fsm_state), 64'(est));
   endtask

   initial begin
      int base;
      // Reset state, held two cycles
      add(1, 0, 8'h00, 0, 0, 1, 0, 0, 0, 1, '0);
      add(1, 1, 8'hFF, 0, 1, 1, 0, 0, 0, 1, '0);
`ifdef OPLOADER_ADDR_WR_EN
      // Byte 2 collides with addressed write 0x5A; byte 4 accept alongside write of byte 0.
      base = vec_q.size();
      stream(8'h01, 6, 0);
      set_wr(base + 2, 3'd2, 8'h5A);
      set_wr(base + 4, 3'd0, 8'hC3);
      add(0, 0, 8'h00, 0, 0, 0, 1, 6, 0, 1, 48'h0605_045A_02C3);
      set_wr(vec_q.size() - 1, 3'd6, 8'hFF);
      add(0, 0, 8'h00, 0, 0, 0, 1, 6, 0, 1, 48'h0605_045A_02C3);
      add(0, 0, 8'h00, 0, 1, 1, 0, 0, 0, 1, 48'h0605_045A_02C3);
      // Addressed write while clear is asserted still lands
      add(0, 0, 8'h00, 1, 0, 1, 0, 0, 0, 1, 48'h0605_045A_0277);
      set_wr(vec_q.size() - 1, 3'd0, 8'h77);
`else
      // 1: back-to-back load
      stream(8'h01, 8, 0);
      add(0, 0, 8'h00, 0, 0, 0, 1, 8, 0, 1, 64'h0807_0605_0403_0201);
      // 2: ack, ack in IDLE ignored, then gapped load with ack in the gaps
      add(0, 0, 8'h00, 0, 1, 1, 0, 0, 0, 1, 64'h0807_0605_0403_0201);
      add(0, 0, 8'h00, 0, 1, 1, 0, 0, 0, 0, '0);
      for (int i = 0; i < 8; i++) begin
         add(0, 1, 8'(8'h11 + i), 0, 0, i < 7, i == 7, i + 1, 0, 0, '0);
         if (i < 7) add(0, 0, 8'h99, 0, 1, 1, 0, i + 1, 0, 0, '0);
      end
      add(0, 0, 8'h00, 0, 0, 0, 1, 8, 0, 1, 64'h1817_1615_1413_1211);
      add(0, 0, 8'h00, 0, 1, 1, 0, 0, 0, 0, '0);
      // 3: overrun in FULL, sticky, then clear
      stream(8'h21, 8, 0);
      add(0, 1, 8'hAA, 0, 0, 0, 1, 8, 1, 1, 64'h2827_2625_2423_2221);
      add(0, 0, 8'h00, 0, 0, 0, 1, 8, 1, 0, '0);
      add(0, 0, 8'h00, 1, 0, 1, 0, 0, 0, 1, 64'h2827_2625_2423_2221);
      // 4: partial load, clear with in_valid, reload
      stream(8'h31, 3, 0);
      add(0, 1, 8'hEE, 1, 0, 1, 0, 0, 0, 1, 64'h2827_2625_2433_3231);
      stream(8'h41, 8, 0);
      add(0, 0, 8'h00, 0, 0, 0, 1, 8, 0, 1, 64'h4847_4645_4443_4241);
      // ack together with in_valid: ack taken, byte dropped, overrun flagged
      add(0, 1, 8'h55, 0, 1, 1, 0, 0, 1, 1, 64'h4847_4645_4443_4241);
      add(0, 0, 8'h00, 1, 0, 1, 0, 0, 0, 0, '0);
      // 5: reset after 5 bytes
      stream(8'h51, 5, 0);
      add(1, 0, 8'h00, 0, 0, 1, 0, 0, 0, 1, '0);
`endif

      foreach (vec_q[i]) begin
         @(negedge clk);
         reset = vec_q[i].rst; in_valid = vec_q[i].vld; in_data = vec_q[i].data;
         clear = vec_q[i].clr; ops_ack = vec_q[i].ack;
         wr_en = vec_q[i].wen; wr_addr = vec_q[i].waddr; wr_data = vec_q[i].wdata;
         @(posedge clk);
         #1;
         compare_outputs(i, vec_q[i].erdy, vec_q[i].evld, vec_q[i].ecnt, vec_q[i].eerr);
         if (vec_q[i].chk) check("ops", i, 64'(ops), 64'(vec_q[i].eops));
      end

      // Hand sequence: fill, then clear with in_valid in FULL -> clear beats overrun.
      @(negedge clk);
      reset = 1'b0; clear = 1'b0; ops_ack = 1'b0; wr_en = 1'b0;
      for (int k = 0; k < TOTAL; k++) begin
         in_valid = 1'b1; in_data = 8'(8'hC0 + k);
         @(negedge clk);
      end
      in_valid = 1'b0;
      compare_outputs(1000, 0, 1, TOTAL, 0);
      check("ops_low_byte", 1000, 64'(ops[7:0]), 64'hC0);
      in_valid = 1'b1; in_data = 8'hBB; clear = 1'b1;
      @(posedge clk);
      #1;
      compare_outputs(1001, 1, 0, 0, 0);
      // Next byte after clear lands in byte 0
      @(negedge clk);
      clear = 1'b0; in_data = 8'hD1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      compare_outputs(1002, 1, TOTAL == 1, 1, 0);
      check("ops_byte0_after_clear", 1002, 64'(ops[7:0]), 64'hD1);
      check("ops_byte1_kept", 1002, 64'(ops[15:8]), 64'hC1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
